// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that lends one SPI master to three requesters.
// Each grant sets up the master, holds it in reset/load, then counts sclk edges to completion.
module spi_xfer_arbiter #(
  parameter int WIDTH        = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         req,
  input  logic [5:0]         req_mode,
  input  logic [5:0]         req_sel,
  input  logic [3*WIDTH-1:0] req_data,
  output logic [2:0]         gnt,
  output logic [2:0]         ack,
  output logic [WIDTH-1:0]   rx_data,
  output logic               err,
  output logic               busy,
  output logic               m_cpol,
  output logic               m_cpha,
  output logic [1:0]         m_select,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_load,
  output logic               m_reset,
  input  logic               m_sclk,
  input  logic [WIDTH-1:0]   m_rx_data
);

  localparam int EDGES = 2 * WIDTH;
  localparam int EW    = $clog2(EDGES + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int SW    = $clog2(SETUP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

  typedef struct packed {
    logic             cpol;
    logic             cpha;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
  } xfer_req_t;

  xfer_req_t [2:0] rq;

  for (genvar i = 0; i < 3; i++) begin : g_req
    assign rq[i] = {req_mode[2*i+1], req_mode[2*i], req_sel[2*i+:2], req_data[WIDTH*i+:WIDTH]};
  end

  state_t           state_q;
  logic [2:0]       gnt_q, ack_q;
  logic [WIDTH-1:0] rx_q, data_q;
  logic             err_q, busy_q, cpol_q, cpha_q, load_q, mrst_q, sclk_q;
  logic [1:0]       sel_q, rr_last_q, gidx_q;
  logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
  logic [TW-1:0]    tmo_cnt_q;
  logic [SW-1:0]    setup_cnt_q;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Scan order starts just after the last winner, so the last winner comes last.
  logic [1:0] c0, c1, pick;
  always_comb begin
    c0   = nxt(rr_last_q);
    c1   = nxt(c0);
    pick = rr_last_q;
    if (req[c0])      pick = c0;
    else if (req[c1]) pick = c1;
  end

  logic sclk_edge;
  assign sclk_edge  = m_sclk ^ sclk_q;
  assign edge_cnt_d = edge_cnt_q + {{(EW-1){1'b0}}, sclk_edge};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      rx_q        <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      sel_q       <= '0;
      data_q      <= '0;
      load_q      <= 1'b1;
      mrst_q      <= 1'b1;
      rr_last_q   <= 2'd2;
      gidx_q      <= '0;
      sclk_q      <= 1'b0;
      edge_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      setup_cnt_q <= '0;
    end else begin
      sclk_q <= m_sclk;
      ack_q  <= '0;
      case (state_q)
        IDLE: begin
          mrst_q <= 1'b0;
          load_q <= 1'b0;
          sel_q  <= '0;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          err_q  <= 1'b0;
          if (|req) begin
            cpol_q      <= rq[pick].cpol;
            cpha_q      <= rq[pick].cpha;
            sel_q       <= rq[pick].sel;
            data_q      <= rq[pick].data;
            gnt_q       <= 3'b001 << pick;
            gidx_q      <= pick;
            busy_q      <= 1'b1;
            mrst_q      <= 1'b1;
            load_q      <= 1'b1;
            setup_cnt_q <= '0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          // sclk_q keeps tracking here, so a CPOL swing while in reset is never an edge.
          edge_cnt_q <= '0;
          tmo_cnt_q  <= '0;
          if (setup_cnt_q == SW'(SETUP_CYCLES - 1)) begin
            mrst_q  <= 1'b0;
            load_q  <= 1'b0;
            state_q <= XFER;
          end else begin
            setup_cnt_q <= setup_cnt_q + 1'b1;
          end
        end
        XFER: begin
          edge_cnt_q <= edge_cnt_d;
          tmo_cnt_q  <= tmo_cnt_q + 1'b1;
          if (edge_cnt_d == EW'(EDGES)) begin
            ack_q   <= gnt_q;
            rx_q    <= m_rx_data;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            ack_q   <= gnt_q;
            rx_q    <= m_rx_data;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          rr_last_q <= gidx_q;
          gnt_q     <= '0;
          busy_q    <= 1'b0;
          sel_q     <= '0;
          err_q     <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign rx_data  = rx_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign m_cpol   = cpol_q;
  assign m_cpha   = cpha_q;
  assign m_select = sel_q;
  assign m_data   = data_q;
  assign m_load   = load_q;
  assign m_reset  = mrst_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter with a behavioural SPI master/slave on the far side.
module tb_spi_xfer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [5:0]  req_mode, req_sel;
  logic [23:0] req_data;
  logic [2:0]  gnt, ack;
  logic [7:0]  rx_data, m_data, m_rx_data;
  logic        err, busy, m_cpol, m_cpha, m_load, m_reset, m_sclk;
  logic [1:0]  m_select;

  spi_xfer_arbiter #(.WIDTH(8), .SETUP_CYCLES(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_mode(req_mode), .req_sel(req_sel),
    .req_data(req_data), .gnt(gnt), .ack(ack), .rx_data(rx_data), .err(err), .busy(busy),
    .m_cpol(m_cpol), .m_cpha(m_cpha), .m_select(m_select), .m_data(m_data),
    .m_load(m_load), .m_reset(m_reset), .m_sclk(m_sclk), .m_rx_data(m_rx_data)
  );

  always #5 clk = ~clk;

  // Master model: idles at CPOL while reset, then 16 sclk edges, shifting the slave byte in MSB first.
  logic       sclk_r = 1'b0;
  logic [7:0] sh = 8'h00, cur_sl = 8'h00;
  logic [7:0] sl_byte [4];
  int         div = 0, ecnt = 16;
  logic       stuck = 1'b0;

  assign m_sclk    = sclk_r;
  assign m_rx_data = sh;

  always @(negedge clk) begin
    if (m_reset) begin
      sclk_r = m_cpol; div = 0; ecnt = 0; sh = 8'h00; cur_sl = sl_byte[m_select];
    end else if (!stuck && ecnt < 16) begin
      div++;
      if (div == 2) begin
        div = 0;
        sclk_r = ~sclk_r;
        if (ecnt % 2 == 1) sh = {sh[6:0], cur_sl[7 - ecnt/2]};
        ecnt++;
      end
    end
  end

  typedef struct {
    logic [2:0] g;
    logic       cpol, cpha;
    logic [1:0] sel;
    logic [7:0] data, rx;
    logic       err;
    int         len;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual timeout required event", nm);
  endtask

  // Monitor: grant checks against the queue head, completion pops and checks.
  initial begin
    exp_t cur, e;
    logic [2:0] prev_g;
    int setup_n, xfer_n;
    prev_g = '0; setup_n = 0; xfer_n = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin prev_g = '0; continue; end
      if (gnt != 3'b000 && prev_g == 3'b000) begin
        setup_n = 0; xfer_n = 0;
        if (q.size() == 0) bound_fail("unexpected_gnt");
        else begin
          cur = q[0];
          chk("gnt", gnt, cur.g);
          chk("m_cpol", m_cpol, cur.cpol);
          chk("m_cpha", m_cpha, cur.cpha);
          chk("m_select", m_select, cur.sel);
          chk("m_data", m_data, cur.data);
        end
      end
      if (busy && m_reset && m_load) setup_n++;
      if (busy && !m_reset && ack == 3'b000) xfer_n++;
      if (ack != 3'b000) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack: actual %b required none", ack);
        end else begin
          e = q.pop_front();
          chk("ack", ack, e.g);
          chk("rx_data", rx_data, e.rx);
          chk("err", err, e.err);
          chk("busy_done", busy, 1'b1);
          chk("setup_cycles", setup_n, 2);
          chk("mode_stable", {m_cpol, m_cpha, m_select, m_data}, {e.cpol, e.cpha, e.sel, e.data});
          if (e.len != 0) chk("xfer_cycles", xfer_n, e.len);
          if (!e.err) chk("sclk_edges", ecnt, 16);
        end
      end
      prev_g = gnt;
    end
  end

  task automatic cfg(input int i, input logic [1:0] mode, input logic [1:0] sel, input logic [7:0] data);
    req_mode[2*i+:2] = mode;
    req_sel[2*i+:2]  = sel;
    req_data[8*i+:8] = data;
  endtask

  task automatic push(input int i, input logic [1:0] mode, input logic [1:0] sel,
                      input logic [7:0] data, input logic [7:0] rx, input logic e_err, input int len);
    exp_t e;
    e.g = 3'b001 << i; e.cpol = mode[1]; e.cpha = mode[0]; e.sel = sel;
    e.data = data; e.rx = rx; e.err = e_err; e.len = len;
    q.push_back(e);
  endtask

  task automatic wait_ack(input int i);
    for (int c = 0; c < 400; c++) begin
      if (ack[i]) return;
      @(posedge clk); #1;
    end
    bound_fail("wait_ack");
  endtask

  task automatic wait_mid(input int k);
    for (int c = 0; c < 400; c++) begin
      if (busy && !m_reset && ecnt >= k) return;
      @(posedge clk); #1;
    end
    bound_fail("wait_mid");
  endtask

  task automatic run_one(input int i, input logic [1:0] mode, input logic [1:0] sel,
                         input logic [7:0] data, input logic [7:0] rx, input logic e_err, input int len);
    cfg(i, mode, sel, data);
    push(i, mode, sel, data, rx, e_err, len);
    req[i] = 1'b1;
    @(posedge clk); #1;
    chk("gnt_latency", gnt, 3'b001 << i);
    wait_ack(i);
    req[i] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    sl_byte[0] = 8'h00; sl_byte[1] = 8'h3C; sl_byte[2] = 8'h00; sl_byte[3] = 8'hC3;
    reset = 1'b1; req = '0; req_mode = '0; req_sel = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {gnt, ack, rx_data, err, busy, m_cpol, m_cpha, m_select, m_data, m_load, m_reset},
        {3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b1});
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", {m_reset, m_load, busy, gnt}, 6'b000000);

    run_one(0, 2'b00, 2'd1, 8'hA5, 8'h3C, 1'b0, 0);

    run_one(1, 2'b00, 2'd2, 8'hA0, 8'h00, 1'b0, 0);
    run_one(1, 2'b01, 2'd2, 8'hA1, 8'h00, 1'b0, 0);
    run_one(1, 2'b11, 2'd2, 8'hA2, 8'h00, 1'b0, 0);
    run_one(1, 2'b10, 2'd2, 8'hA3, 8'h00, 1'b0, 0);

    stuck = 1'b1;
    run_one(0, 2'b00, 2'd1, 8'h5E, 8'h00, 1'b1, 64);
    stuck = 1'b0;
    run_one(0, 2'b00, 2'd1, 8'hA5, 8'h3C, 1'b0, 0);

    // Reset in the middle of a transfer: that transfer is abandoned without an ack.
    cfg(1, 2'b00, 2'd3, 8'h99);
    push(1, 2'b00, 2'd3, 8'h99, 8'hC3, 1'b0, 0);
    req[1] = 1'b1;
    wait_mid(5);
    q.delete();
    reset = 1'b1; req = '0;
    @(posedge clk); #1;
    chk("midreset_outputs", {m_reset, m_load, gnt, busy, ack}, {1'b1, 1'b1, 3'b000, 1'b0, 3'b000});
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    cfg(0, 2'b00, 2'd1, 8'h11);
    cfg(1, 2'b01, 2'd3, 8'h22);
    cfg(2, 2'b10, 2'd2, 8'h33);
    for (int r = 0; r < 2; r++) begin
      push(0, 2'b00, 2'd1, 8'h11, 8'h3C, 1'b0, 0);
      push(1, 2'b01, 2'd3, 8'h22, 8'hC3, 1'b0, 0);
      push(2, 2'b10, 2'd2, 8'h33, 8'h00, 1'b0, 0);
    end
    req = 3'b111;
    n = 0;
    for (int c = 0; c < 1500 && n < 6; c++) begin
      @(posedge clk); #1;
      if (ack != 3'b000) n++;
    end
    if (n < 6) bound_fail("rotate_acks");
    req = '0;
    @(posedge clk); #1;

    // Requester 2 drops mid-transfer; requester 0 waits its turn with no slave selected.
    cfg(2, 2'b11, 2'd1, 8'h5A);
    cfg(0, 2'b00, 2'd0, 8'h77);
    push(2, 2'b11, 2'd1, 8'h5A, 8'h3C, 1'b0, 0);
    push(0, 2'b00, 2'd0, 8'h77, 8'h00, 1'b0, 0);
    req[2] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b1;
    wait_mid(4);
    req[2] = 1'b0;
    wait_ack(2);
    @(posedge clk); #1;
    wait_ack(0);
    req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Shares the single SPI master among three requesters with round-robin arbitration. For each granted request it configures the master's mode (CPOL/CPHA), slave select and transmit byte, then pulses the master's reset/load. It counts sclk edges to detect the end of the 8-bit transfer and returns the received byte with a one-cycle acknowledge. It sits between the system-side requesters and the master instance.

Parameters:
WIDTH, 8, bits per transfer; completion after 2*WIDTH sclk edges.
SETUP_CYCLES, 2, clk cycles m_reset/m_load are held high before the transfer starts (must be ≥1).
TIMEOUT, 64, max clk cycles in XFER before abort.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
req  in  3  per-requester request; held high until ack.
req_mode  in  6  {CPOL,CPHA} per requester; bits [2i+1:2i] for requester i.
req_sel  in  6  slave select per requester, values 1..3 (→cs1..cs3); bits [2i+1:2i].
req_data  in  3*WIDTH  tx byte per requester; bits [WIDTH*i+:WIDTH].
gnt  out  3  one-hot current grant; 0 when idle.
ack  out  3  one-cycle completion pulse to the granted requester.
rx_data  out  WIDTH  byte received from the master; valid when ack is high, held until the next ack.
err  out  1  high with ack when the transfer timed out.
busy  out  1  high in every state except IDLE.
m_cpol, m_cpha  out  1 each  mode to master.
m_select  out  2  slave select to master.
m_data  out  WIDTH  initialize_data to master.
m_load, m_reset  out  1 each  master load/reset.
m_sclk  in  1  master sclk.
m_rx_data  in  WIDTH  master_data.

Behaviour:
- All outputs are registered. Reset values:
  - gnt=0, ack=0, rx_data=0, err=0, busy=0.
  - m_cpol=0, m_cpha=0, m_select=0, m_data=0.
  - m_load=1, m_reset=1 (master held in reset while the arbiter is in reset).
  - Round-robin pointer rr_last=2, so requester 0 has top priority first.
- States: IDLE, SETUP, XFER, DONE.
- IDLE:
  - Outputs: m_reset=0, m_load=0, m_select=0, gnt=0.
  - If req≠0: pick the first asserted requester scanning rr_last+1, rr_last+2, rr_last (mod 3).
  - Latch that requester's mode/sel/data into m_cpol/m_cpha/m_select/m_data. Set gnt one-hot and busy=1. Go to SETUP.
  - Grant decision takes one cycle: req high at edge n gives gnt at edge n+1.
- SETUP:
  - m_reset=1, m_load=1 for exactly SETUP_CYCLES cycles, then both drop to 0 on entry to XFER.
  - Clear the edge counter and timeout counter.
  - sclk_q tracks m_sclk every cycle, so polarity changes during SETUP are never counted.
- XFER:
  - edge = m_sclk ≠ sclk_q (sclk_q is m_sclk registered).
  - Count edges. When the count reaches 2*WIDTH, go to DONE with err=0.
  - If TIMEOUT cycles elapse first, go to DONE with err=1.
  - m_cpol/m_cpha/m_select/m_data are stable for the whole of SETUP and XFER.
- DONE (one cycle):
  - ack[g]=1 for the granted requester only. rx_data ← m_rx_data. err as set in XFER.
  - rr_last ← g. Next state is IDLE, where gnt=0, busy=0, m_select=0.
- Boundaries:
  - req dropped mid-transfer: no abort; the transfer completes and ack still pulses.
  - Re-request by the same requester: it is granted again only if no other requester is asserted.
  - All three requesting continuously: grants rotate 0,1,2,0…
  - New req during DONE: not sampled until IDLE, so minimum one idle cycle between transfers.
  - req_sel=0 is passed through unchanged (no slave selected); the transfer still runs.
  - reset mid-transfer: next cycle all outputs at reset values, state IDLE, no ack.

Test Plan:
- reset=1 for 2 cycles, then 0; req=3'b001, mode 00, sel 1, data 8'hA5, slave returning 8'h3C → gnt=001 one cycle later; m_reset/m_load high 2 cycles; ack[0] pulses once after 16 sclk edges; rx_data=8'h3C; err=0.
- Mode sweep: repeat with req_mode 00, 01, 11, 10 on requester 1 → m_cpol/m_cpha match each mode; 16 edges counted per transfer; loopback slave data 8'h00 returned each time.
- req=3'b111 held for 6 transfers → grant order 0,1,2,0,1,2; exactly one ack per transfer, on the matching bit.
- Force m_sclk stuck at 0 → after 64 XFER cycles, DONE with err=1 and ack pulse; next request proceeds normally.
- Assert reset at edge 5 of XFER → m_reset=1, gnt=0, busy=0 the next cycle; no ack; a fresh request after reset completes correctly.
- Requester 2 drops req mid-XFER → ack[2] still pulses; requester 0 pending is granted next.
